// File: rtl/fpga_pkg.sv
// fpga_pkg: shared defaults and width helper for the board-level top.
package fpga_pkg;

    localparam int DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int DEF_BLINK_HZ    = 1;
    localparam int DEF_AUX_WINDOW  = 16;

    // ceil(log2(n)), never less than one bit
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fpga_blinker.sv
// fpga_blinker: toggle counter that wraps at a runtime-selectable limit.
module fpga_blinker
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] limit,
    output logic         led
);

    logic [W-1:0] cnt;

    // >= rather than == so a shrinking limit wraps at once instead of overrunning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            led <= 1'b0;
        end else if (cnt >= limit - 1'b1) begin
            cnt <= '0;
            led <= ~led;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_top.sv
// fpga_top: LED heartbeat, aux oscillator request and aux liveness monitor.
// Define AUX_FAULT_EN to drive LEDR3 with the sticky aux fault instead of SW1.
module fpga_top
    import fpga_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int BLINK_HZ    = DEF_BLINK_HZ,
    parameter int AUX_WINDOW  = DEF_AUX_WINDOW
) (
    input  logic fpga_CLK,
    input  logic fpga_NRST,
    input  logic fpga_CLK_AUX,
    input  logic fpga_SW0,
    input  logic fpga_SW1,
    output logic fpga_LEDR0,
    output logic fpga_LEDR1,
    output logic fpga_LEDR2,
    output logic fpga_LEDR3,
    output logic fpga_SEL_CLK_AUX
);

    localparam int HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int CW   = cnt_width(HALF + 1);
    localparam int AW   = cnt_width(AUX_WINDOW + 1);

    localparam logic [CW-1:0] LIM_LONG  = CW'(HALF);
    localparam logic [CW-1:0] LIM_SHORT = CW'(HALF / 4);
    localparam logic [AW-1:0] WIN       = AW'(AUX_WINDOW);

    logic sw0_m, sw0_s;
    logic sw1_m, sw1_s;
    logic aux_m, a_s, a_d;
    logic aux_edge;
    logic [AW-1:0] alive;
    logic [CW-1:0] lim0;

    // aux is only ever sampled as data, never used as a clock
    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            sw0_m <= 1'b0;
            sw0_s <= 1'b0;
            sw1_m <= 1'b0;
            sw1_s <= 1'b0;
            aux_m <= 1'b0;
            a_s   <= 1'b0;
            a_d   <= 1'b0;
        end else begin
            sw0_m <= fpga_SW0;
            sw0_s <= sw0_m;
            sw1_m <= fpga_SW1;
            sw1_s <= sw1_m;
            aux_m <= fpga_CLK_AUX;
            a_s   <= aux_m;
            a_d   <= a_s;
        end
    end

    assign aux_edge = a_s ^ a_d;
    assign fpga_SEL_CLK_AUX = sw0_s;

    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            alive <= '0;
        end else if (aux_edge) begin
            alive <= WIN;
        end else if (alive != '0) begin
            alive <= alive - 1'b1;
        end
    end

    assign fpga_LEDR2 = (alive != '0);
    assign lim0 = sw1_s ? LIM_SHORT : LIM_LONG;

    fpga_blinker #(.W(CW)) u_blink0 (
        .clk   (fpga_CLK),
        .rst_n (fpga_NRST),
        .limit (lim0),
        .led   (fpga_LEDR0)
    );

    fpga_blinker #(.W(CW)) u_blink1 (
        .clk   (fpga_CLK),
        .rst_n (fpga_NRST),
        .limit (LIM_LONG),
        .led   (fpga_LEDR1)
    );

`ifdef AUX_FAULT_EN
    logic [AW-1:0] grace;
    logic          fault;

    // a fresh aux edge beats the fault-set condition in the same cycle
    always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
        if (!fpga_NRST) begin
            grace <= '0;
            fault <= 1'b0;
        end else begin
            if (!sw0_s) begin
                grace <= '0;
            end else if (grace != WIN) begin
                grace <= grace + 1'b1;
            end
            if (!sw0_s) begin
                fault <= 1'b0;
            end else if (grace == WIN && alive == '0 && !aux_edge) begin
                fault <= 1'b1;
            end
        end
    end

    assign fpga_LEDR3 = fault;
`else
    assign fpga_LEDR3 = sw1_s;
`endif

endmodule

// File: tb/tb_fpga_top.sv
// tb_fpga_top: vector tables, directed corner sequences and a random run
// against a behavioural model of fpga_top (HALF=50, AUX_WINDOW=16).
module tb_fpga_top;

    localparam int CF   = 100;
    localparam int BH   = 1;
    localparam int AW   = 16;
    localparam int HALF = 50;
    localparam int NR   = 3000;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic aux = 1'b0;
    logic sw0 = 1'b0;
    logic sw1 = 1'b0;
    logic led0, led1, led2, led3, sel;
    logic aux_run = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit sw0;
        bit sw1;
        int edges;
        bit e_sel;
        bit e_echo;
    } vec_t;

    vec_t tv[9];

    bit h0[NR+4];
    bit h1[NR+4];
    bit ha[NR+4];
    int run[NR+4];

    fpga_top #(
        .CLK_FREQ_HZ (CF),
        .BLINK_HZ    (BH),
        .AUX_WINDOW  (AW)
    ) dut (
        .fpga_CLK         (clk),
        .fpga_NRST        (nrst),
        .fpga_CLK_AUX     (aux),
        .fpga_SW0         (sw0),
        .fpga_SW1         (sw1),
        .fpga_LEDR0       (led0),
        .fpga_LEDR1       (led1),
        .fpga_LEDR2       (led2),
        .fpga_LEDR3       (led3),
        .fpga_SEL_CLK_AUX (sel)
    );

    always #10 clk = ~clk;

    // free-running aux at 18 ns, offset so it never lands on a clock edge
    initial begin
        #1;
        forever begin
            #18;
            if (aux_run && sel) aux = ~aux;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit s0, input bit s1);
        @(negedge clk);
        nrst = 1'b0;
        aux_run = 1'b0;
        aux = 1'b0;
        sw0 = s0;
        sw1 = s1;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0[$];
        int t1[$];
        logic p0, p1;
        int cnt, bad, prevt, maxgap;
        bit sel_e, sel_p, ld, al0;
        int lastload, since, lim, mode;
        bit l0m, fm;

        tv[0] = '{1'b1, 1'b1, 1, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1, 1'b1, 1'b1};
        tv[2] = '{1'b0, 1'b1, 1, 1'b1, 1'b1};
        tv[3] = '{1'b0, 1'b0, 1, 1'b0, 1'b1};
        tv[4] = '{1'b0, 1'b0, 1, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b1, 2, 1'b1, 1'b1};
        tv[6] = '{1'b0, 1'b1, 1, 1'b1, 1'b1};
        tv[7] = '{1'b1, 1'b1, 1, 1'b0, 1'b1};
        tv[8] = '{1'b1, 1'b1, 1, 1'b1, 1'b1};

        // reset held with both switches on
        nrst = 1'b0;
        sw0 = 1'b1;
        sw1 = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_led0", led0, 0);
        chk("rst_led1", led1, 0);
        chk("rst_led2", led2, 0);
        chk("rst_led3", led3, 0);
        chk("rst_sel", sel, 0);
        nrst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            sw0 = tv[i].sw0;
            sw1 = tv[i].sw1;
            repeat (tv[i].edges) edge1();
            chk($sformatf("vec%0d_sel", i), sel, tv[i].e_sel);
`ifndef AUX_FAULT_EN
            chk($sformatf("vec%0d_led3", i), led3, tv[i].e_echo);
`endif
        end

        // heartbeat with SW1=0
        do_reset(1'b0, 1'b0);
        p0 = 1'b0;
        p1 = 1'b0;
        for (int e = 1; e <= 160; e++) begin
            edge1();
            if (led1 !== p1) begin t1.push_back(e); p1 = led1; end
            if (led0 !== p0) begin t0.push_back(e); p0 = led0; end
        end
        chk("led1_ntog", t1.size(), 3);
        chk("led0_ntog", t0.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < t1.size()) chk("led1_tog_edge", t1[i], HALF * (i + 1));
            if (i < t0.size()) chk("led0_tog_edge", t0[i], HALF * (i + 1));
        end

        // fast blink: first toggle within 15 cycles, then every 12
        sw1 = 1'b1;
        t0.delete();
        for (int e = 161; e <= 260; e++) begin
            edge1();
            if (led0 !== p0) begin t0.push_back(e); p0 = led0; end
        end
        prevt = 150;
        maxgap = 0;
        foreach (t0[i]) begin
            if (t0[i] - prevt > maxgap) maxgap = t0[i] - prevt;
            prevt = t0[i];
        end
        chk("led0_fast_ntog_ok", t0.size() >= 7, 1);
        if (t0.size() > 0) chk("led0_fast_first_ok", t0[0] <= 175, 1);
        chk("led0_gap_le50", maxgap <= HALF, 1);
        for (int i = 1; i < t0.size(); i++)
            chk("led0_fast_gap", t0[i] - t0[i-1], HALF / 4);

        // async reset between edges while LEDR1 is lit
        cnt = 0;
        while (led1 !== 1'b1 && cnt < 120) begin edge1(); cnt++; end
        chk("led1_high_seen", led1, 1);
        #5;
        nrst = 1'b0;
        #1;
        chk("async_led0", led0, 0);
        chk("async_led1", led1, 0);
        chk("async_led2", led2, 0);
        chk("async_led3", led3, 0);
        chk("async_sel", sel, 0);
        sw0 = 1'b0;
        sw1 = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        cnt = 0;
        while (led1 === 1'b0 && cnt < 60) begin edge1(); cnt++; end
        chk("restart_led1_edge", cnt, HALF);

        // aux alive
        do_reset(1'b1, 1'b0);
        repeat (2) edge1();
        chk("aux_sel_up", sel, 1);
        @(negedge clk);
        aux = 1'b1;
        cnt = 0;
        while (led2 !== 1'b1 && cnt < 10) begin edge1(); cnt++; end
        chk("aux_rise_lat", cnt, 3);
        aux_run = 1'b1;
        bad = 0;
        for (int e = 0; e < 60; e++) begin
            edge1();
            if (led2 !== 1'b1) bad++;
        end
        chk("aux_stays_alive", bad, 0);
        aux_run = 1'b0;
        cnt = 0;
        while (led2 === 1'b1 && cnt < 30) begin edge1(); cnt++; end
        chk("aux_dead_lat_ok", cnt >= 16 && cnt <= 19, 1);

`ifdef AUX_FAULT_EN
        // fault with stuck aux, stickiness, clear on SW0 release
        do_reset(1'b0, 1'b0);
        repeat (3) edge1();
        sw0 = 1'b1;
        cnt = 0;
        while (sel !== 1'b1 && cnt < 10) begin edge1(); cnt++; end
        chk("flt_sel_lat", cnt, 2);
        for (int k = 1; k <= 17; k++) begin
            edge1();
            if (k == 16) chk("flt_not_yet", led3, 0);
            if (k == 17) chk("flt_set", led3, 1);
        end
        aux_run = 1'b1;
        bad = 0;
        for (int e = 0; e < 40; e++) begin
            edge1();
            if (led3 !== 1'b1) bad++;
        end
        chk("flt_sticky", bad, 0);
        chk("flt_aux_alive", led2, 1);
        sw0 = 1'b0;
        edge1();
        chk("flt_hold1", led3, 1);
        edge1();
        chk("flt_hold2", led3, 1);
        edge1();
        chk("flt_clear", led3, 0);
        aux_run = 1'b0;
`endif

        // random run against the behavioural model
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < NR + 4; i++) begin
            h0[i] = 1'b0; h1[i] = 1'b0; ha[i] = 1'b0; run[i] = 0;
        end
        lastload = -100;
        since = 0;
        l0m = 1'b0;
        fm = 1'b0;
        mode = 0;
        for (int m = 1; m <= NR; m++) begin
            if ($urandom_range(63) == 0) sw0 = ~sw0;
            if ($urandom_range(39) == 0) sw1 = ~sw1;
            if (m % 50 == 1) mode = $urandom_range(2);
            if (mode == 1) aux = ~aux;
            else if (mode == 2 && $urandom_range(2) == 0) aux = ~aux;
            h0[m+3] = sw0;
            h1[m+3] = sw1;
            ha[m+3] = aux;
            @(negedge clk);
            // value seen at edge k lives at index k+3
            sel_e = h0[m+2];
            sel_p = h0[m+1];
            run[m+3] = sel_e ? run[m+2] + 1 : 0;
            ld = (ha[m+1] != ha[m]);
            al0 = (m - 1 - lastload) >= AW;
            if (!sel_p) fm = 1'b0;
            else if (run[m+1] >= AW && al0 && !ld) fm = 1'b1;
            if (ld) lastload = m;
            lim = h1[m+1] ? HALF / 4 : HALF;
            if (since + 1 >= lim) begin since = 0; l0m = ~l0m; end
            else since++;
            chk("rnd_sel", sel, sel_e);
            chk("rnd_led1", led1, (m / HALF) % 2);
            chk("rnd_led0", led0, l0m);
            chk("rnd_led2", led2, (m - lastload) < AW);
`ifdef AUX_FAULT_EN
            chk("rnd_led3", led3, fm);
`else
            chk("rnd_led3", led3, h1[m+2]);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
